operand_fetch_unit: RTL

- Initiator/client side of the 32-entry, two-read/one-write word register file. It drives `read_a`, `read_b`, `write_select` and `write_in`.
- Accepts decoded instructions over a valid/ready handshake and fetches both source operands.
- Tracks in-flight destinations in a 32-bit scoreboard, stalls on RAW/WAW hazards, and presents operands to execute through a single registered output stage.
- Sits between decode and execute; the writeback stage returns results through it.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/operand_fetch_unit_reg_scoreboard.sv | 43 ++++
 rtl/operand_fetch_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared register-file types and constants for the operand fetch slice.
// Provides address range checking and one-hot masking for the pending scoreboard.
package cpu_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 32;
    localparam int IDX_W    = $clog2(NUM_REGS);

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_addr_t NO_WRITE  = 6'd63;
    localparam reg_addr_t REG_LIMIT = reg_addr_t'(NUM_REGS);

    function automatic logic in_range(input reg_addr_t addr);
        return (addr < REG_LIMIT);
    endfunction

    // Out-of-range addresses never hit, so a stray select cannot stall issue.
    function automatic logic is_pending(input logic [NUM_REGS-1:0] vec, input reg_addr_t addr);
        logic hit;
        if (in_range(addr)) begin
            hit = vec[addr[IDX_W-1:0]];
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    function automatic logic [NUM_REGS-1:0] addr_mask(input logic en, input reg_addr_t addr);
        logic [NUM_REGS-1:0] m;
        m = {NUM_REGS{1'b0}};
        if (en && in_range(addr)) begin
            m[addr[IDX_W-1:0]] = 1'b1;
        end else begin
            m = {NUM_REGS{1'b0}};
        end
        return m;
    endfunction

endpackage

// File: rtl/operand_fetch_unit_reg_scoreboard.sv
// Pending-destination scoreboard: one bit per architectural register, set on
// issue, cleared on writeback, looked up for two sources and one destination.
module reg_scoreboard
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      set_en,
    input  reg_addr_t set_addr,
    input  logic      clr_en,
    input  reg_addr_t clr_addr,
    input  reg_addr_t look_a,
    input  reg_addr_t look_b,
    input  reg_addr_t look_d,
    output logic      hit_a,
    output logic      hit_b,
    output logic      hit_d
);

    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;

    assign set_mask_s = addr_mask(set_en, set_addr);
    assign clr_mask_s = addr_mask(clr_en, clr_addr);

    // Set is applied after clear so a same-edge reissue keeps its destination pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= {NUM_REGS{1'b0}};
        end else begin
            pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
        end
    end

    // Lookups see only the registered vector.
    always_comb begin
        hit_a = is_pending(pending_r, look_a);
        hit_b = is_pending(pending_r, look_b);
        hit_d = is_pending(pending_r, look_d);
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch: reads both sources from the register file, stalls on RAW/WAW
// hazards, and holds operands in one registered stage. Optional writeback
// forwarding is enabled with the OPERAND_FETCH_WB_BYPASS_EN macro.
module operand_fetch_unit
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      in_valid,
    output logic      in_ready,
    input  reg_addr_t in_src_a,
    input  reg_addr_t in_src_b,
    input  logic      in_use_a,
    input  logic      in_use_b,
    input  reg_addr_t in_dst,
    input  logic      in_dst_en,
    output reg_addr_t rf_read_a,
    output reg_addr_t rf_read_b,
    input  word_t     rf_out_a,
    input  word_t     rf_out_b,
    output reg_addr_t rf_write_select,
    output word_t     rf_write_in,
    input  logic      wb_valid,
    input  reg_addr_t wb_dst,
    input  word_t     wb_data,
    output logic      op_valid,
    input  logic      op_ready,
    output word_t     op_a,
    output word_t     op_b,
    output reg_addr_t op_dst,
    output logic      op_dst_en
);

    logic      hit_a_s, hit_b_s, hit_d_s;
    logic      byp_a_s, byp_b_s, byp_d_s;
    logic      hazard_s, out_free_s, ready_s, issue_s;
    word_t     opnd_a_s, opnd_b_s;
    logic      op_valid_r, op_dst_en_r;
    word_t     op_a_r, op_b_r;
    reg_addr_t op_dst_r;

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue_s && in_dst_en),
        .set_addr (in_dst),
        .clr_en   (wb_valid),
        .clr_addr (wb_dst),
        .look_a   (in_src_a),
        .look_b   (in_src_b),
        .look_d   (in_dst),
        .hit_a    (hit_a_s),
        .hit_b    (hit_b_s),
        .hit_d    (hit_d_s)
    );

`ifdef OPERAND_FETCH_WB_BYPASS_EN
    // Same-cycle writeback matches are forwarded and exempt from the hazard check.
    always_comb begin
        byp_a_s = wb_valid && (wb_dst == in_src_a);
        byp_b_s = wb_valid && (wb_dst == in_src_b);
        byp_d_s = wb_valid && (wb_dst == in_dst);
    end
`else
    // Without forwarding a source waits until the writeback has landed.
    always_comb begin
        byp_a_s = 1'b0;
        byp_b_s = 1'b0;
        byp_d_s = 1'b0;
    end
`endif

    // Operand select, hazard and handshake.
    always_comb begin
        if (byp_a_s) begin
            opnd_a_s = wb_data;
        end else begin
            opnd_a_s = rf_out_a;
        end
        if (byp_b_s) begin
            opnd_b_s = wb_data;
        end else begin
            opnd_b_s = rf_out_b;
        end
        hazard_s   = (in_use_a  && hit_a_s && !byp_a_s) ||
                     (in_use_b  && hit_b_s && !byp_b_s) ||
                     (in_dst_en && hit_d_s && !byp_d_s);
        out_free_s = !op_valid_r || op_ready;
        ready_s    = out_free_s && !hazard_s;
        issue_s    = in_valid && ready_s;
    end

    // Register-file write port idles on an address no register decodes.
    always_comb begin
        if (wb_valid) begin
            rf_write_select = wb_dst;
        end else begin
            rf_write_select = NO_WRITE;
        end
    end

    assign rf_read_a   = in_src_a;
    assign rf_read_b   = in_src_b;
    assign rf_write_in = wb_data;
    assign in_ready    = ready_s;

    // Output stage: load on issue, drop valid once execute takes it, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_valid_r  <= 1'b0;
            op_a_r      <= 32'd0;
            op_b_r      <= 32'd0;
            op_dst_r    <= 6'd0;
            op_dst_en_r <= 1'b0;
        end else if (issue_s) begin
            op_valid_r  <= 1'b1;
            op_a_r      <= opnd_a_s;
            op_b_r      <= opnd_b_s;
            op_dst_r    <= in_dst;
            op_dst_en_r <= in_dst_en;
        end else if (op_ready) begin
            op_valid_r  <= 1'b0;
        end else begin
            op_valid_r  <= op_valid_r;
        end
    end

    assign op_valid  = op_valid_r;
    assign op_a      = op_a_r;
    assign op_b      = op_b_r;
    assign op_dst    = op_dst_r;
    assign op_dst_en = op_dst_en_r;

endmodule
